msg_uart_tx: RTL and testbench
==============================

Name: msg_uart_tx

Overview:
- Downstream consumer of the miner core's message output. It captures the 1024-bit message when delivery_msg rises, strips leading 0x00 padding bytes, and sends the remaining bytes over a UART line at 8N1.
- Carries periodic nonce progress messages ("^!!"…"!!") and the found-nonce message ("^--"…"--") to the host PC.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated (434 at defaults).
- MSG_BYTES, 128, message width in bytes; msg_in width = 8*MSG_BYTES.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- msg_in  in  8*MSG_BYTES  message, byte 0 = msg_in[top:top-7], sent first.
- delivery_msg  in  1  message-valid level from the miner core; only its rising edge triggers a send.
- tx  out  1  UART serial line, idle high.
- busy  out  1  high from the capture cycle until the last stop bit completes.
- dropped  out  1  one-cycle pulse when a trigger is rejected because busy=1.

Behaviour:
- Reset values: tx=1, busy=0, dropped=0, state IDLE, all counters 0. Reset mid-frame forces tx=1 immediately (asynchronous); any partial byte is abandoned.
- Trigger path:
  - delivery_msg passes through a 2-flop synchronizer, then an edge detector (prev flop).
  - Trigger = sync==1 && prev==0.
  - A level held high never retriggers.
- Trigger in IDLE: in the same cycle, msg_in is latched into a shift buffer, the byte index is set to 0, busy=1, and the next state is SCAN.
- Trigger while busy: ignored; dropped=1 for exactly that cycle; the buffer is untouched.
- SCAN:
  - Examines one byte per cycle.
  - Byte==0x00: index+1.
  - Byte!=0x00: go to START.
  - Index reaches MSG_BYTES with all bytes zero: go to IDLE with busy=0, tx untouched, no frame sent.
  - Zero bytes after the first non-zero byte are transmitted as data.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles.
- NEXT: index+1. If index==MSG_BYTES go to IDLE (busy=0 in the following cycle), otherwise go to START. There is no extra idle bit between bytes.
- Frame time: 10*CLKS_PER_BIT cycles per byte.
- Total busy cycles = 1 (capture) + k (leading zeros scanned) + 1 (first non-zero byte found) + N*(10*CLKS_PER_BIT + 1), where N is the number of bytes sent.
- Bit counter: 3 bits, no wrap beyond 7. Baud counter width is clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and then resets.
- Simultaneous events: a trigger in the same cycle that NEXT returns to IDLE is dropped (busy still 1).
- msg_in is sampled only at capture; later changes are ignored.

Optional Feature:
- Macro: MSG_UART_CRLF_EN.
- Defined: after the last message byte, two more frames 0x0D then 0x0A are sent before IDLE; busy covers them. An all-zero message sends nothing, not even CR/LF.
- Undefined: the block returns to IDLE directly after the last message byte.

Decomposition:
- Package miner_pkg holds:
  - UART_IDLE=1'b1, START_BIT=1'b0, BITS_PER_BYTE=8;
  - the state enum {IDLE, SCAN, START, DATA, STOP, NEXT};
  - CR=8'h0D, LF=8'h0A;
  - a function clks_per_bit(clk_hz, baud).
- One sub-module, uart_tx_byte: takes a byte plus a go strobe and returns a done strobe, owning the START/DATA/STOP timing. msg_uart_tx keeps the IDLE/SCAN/NEXT sequencing and the buffer.

Test Plan (bench uses CLK_HZ=1000, BAUD=100 -> 10 clocks/bit, MSG_BYTES=128):
- msg_in = {"^!!", 32'h02F79DCA, "!!"} zero-extended, raise delivery_msg -> UART decoder receives exactly 5E 21 21 02 F7 9D CA 21 21 (9 bytes); busy=0 after 1+119+1+9*101 = 1030 cycles from capture.
- Same message with MSG_UART_CRLF_EN defined -> 9 bytes then 0D 0A.
- msg_in = all zeros, pulse delivery_msg -> tx stays 1 throughout; busy high for 129 cycles (1 capture + 128 scan).
- During the 3rd byte, delivery_msg falls and rises again -> dropped pulses once (one cycle wide), and the original 9 bytes complete unchanged.
- delivery_msg held high for 5000 cycles -> exactly one message sent.
- Assert reset during DATA bit 4 of byte 2 -> tx=1 asynchronously, busy=0, dropped=0. A new trigger after release sends the full message from byte 0.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared constants, state encoding and helpers for the miner-to-host UART message path.
package miner_pkg;

    localparam logic       UART_IDLE     = 1'b1;
    localparam logic       START_BIT     = 1'b0;
    localparam int         BITS_PER_BYTE = 8;
    localparam logic [7:0] CR            = 8'h0D;
    localparam logic [7:0] LF            = 8'h0A;

    typedef enum logic [2:0] {IDLE, SCAN, START, DATA, STOP, NEXT} state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 byte serializer: a go strobe loads a byte, done is high in the last stop-bit cycle.
module uart_tx_byte
    import miner_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(BITS_PER_BYTE - 1);

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    // Combinational so the sequencer can issue the next go with no extra idle cycle.
    assign done    = (state == STOP) && bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= UART_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (go) begin
                        shift <= data;
                        tx    <= START_BIT;
                        state <= START;
                    end else begin
                        tx <= UART_IDLE;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            tx    <= UART_IDLE;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/msg_uart_tx.sv
// Captures a miner message on delivery_msg rising, skips leading 0x00 bytes and streams the rest at 8N1.
// Define MSG_UART_CRLF_EN to append CR LF after every non-empty message.
module msg_uart_tx
    import miner_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int MSG_BYTES = 128
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [8*MSG_BYTES-1:0] msg_in,
    input  logic                   delivery_msg,
    output logic                   tx,
    output logic                   busy,
    output logic                   dropped
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
`ifdef MSG_UART_CRLF_EN
    localparam int TOTAL_BYTES = MSG_BYTES + 2;
`else
    localparam int TOTAL_BYTES = MSG_BYTES;
`endif
    localparam int               IDX_W     = $clog2(MSG_BYTES + 3);
    localparam logic [IDX_W-1:0] MSG_END   = IDX_W'(MSG_BYTES);
    localparam logic [IDX_W-1:0] TOTAL_END = IDX_W'(TOTAL_BYTES);

    state_t                 state;
    logic [8*MSG_BYTES-1:0] buffer;
    logic [8*MSG_BYTES-1:0] buffer_shifted;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_next;
    logic                   sync1, sync2, prev;
    logic                   trigger;
    logic                   go;
    logic                   done;
    logic [7:0]             head;
    logic [7:0]             tx_byte;

    assign head           = buffer[8*MSG_BYTES-1 -: 8];
    assign buffer_shifted = {buffer[8*MSG_BYTES-9:0], 8'h00};
    assign idx_next       = idx + 1'b1;
    assign trigger        = sync2 & ~prev;

`ifdef MSG_UART_CRLF_EN
    assign tx_byte = (idx == MSG_END) ? CR : ((idx > MSG_END) ? LF : head);
`else
    assign tx_byte = head;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= delivery_msg;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // The buffer advances and idx counts up as each byte completes, so in NEXT the head is already the following byte.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            buffer  <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            dropped <= 1'b0;
            go      <= 1'b0;
        end else begin
            dropped <= trigger && (state != IDLE);
            go      <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        buffer <= msg_in;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (idx == MSG_END) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (head != 8'h00) begin
                        go    <= 1'b1;
                        state <= START;
                    end else begin
                        buffer <= buffer_shifted;
                        idx    <= idx_next;
                    end
                end
                START: state <= DATA;
                DATA: begin
                    if (done) begin
                        buffer <= buffer_shifted;
                        idx    <= idx_next;
                        go     <= (idx_next != TOTAL_END);
                        state  <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx == TOTAL_END) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (CLOCK_50),
        .rst_n(reset),
        .go   (go),
        .data (tx_byte),
        .tx   (tx),
        .done (done)
    );

endmodule

// File: tb/tb_msg_uart_tx.sv
// Scoreboard bench for msg_uart_tx: stimulus queues expected bytes, a UART decoder pops and compares them.
module tb_msg_uart_tx;

    localparam int CLK_HZ    = 1000;
    localparam int BAUD      = 100;
    localparam int MSG_BYTES = 128;
    localparam int CPB       = 10;
`ifdef MSG_UART_CRLF_EN
    localparam int TAIL = 2;
`else
    localparam int TAIL = 0;
`endif
    localparam int N_SENT    = 9 + TAIL;
    localparam int MSG_BUSY  = 1 + 119 + 1 + N_SENT * (10 * CPB + 1);
    localparam int ZERO_BUSY = 1 + 128;
    localparam logic [8*MSG_BYTES-1:0] TEST_MSG = (8*MSG_BYTES)'({"^!!", 32'h02F79DCA, "!!"});

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   delivery_msg = 1'b0;
    logic [8*MSG_BYTES-1:0] msg_in = '0;
    logic                   tx, busy, dropped;

    int         checks = 0;
    int         failures = 0;
    int         rx_count = 0;
    int         drop_pulses = 0;
    int         drop_cycles = 0;
    logic       drop_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_bytes [9] = '{8'h5E, 8'h21, 8'h21, 8'h02, 8'hF7, 8'h9D, 8'hCA, 8'h21, 8'h21};

    always #5 clk = ~clk;

    msg_uart_tx #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .MSG_BYTES(MSG_BYTES)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (rst_n),
        .msg_in      (msg_in),
        .delivery_msg(delivery_msg),
        .tx          (tx),
        .busy        (busy),
        .dropped     (dropped)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic push_expected();
        for (int i = 0; i < 9; i++) exp_q.push_back(exp_bytes[i]);
`ifdef MSG_UART_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic apply_stimulus(input logic [8*MSG_BYTES-1:0] msg, input logic expect_frame);
        @(negedge clk);
        msg_in = msg;
        if (expect_frame) push_expected();
        delivery_msg = 1'b1;
    endtask

    task automatic release_msg();
        @(negedge clk);
        delivery_msg = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic measure_busy(output int busy_n, output int tx_low_n);
        int guard = 0;
        busy_n = 0;
        tx_low_n = 0;
        while (!busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        while (busy && busy_n < 4000) begin
            if (!tx) tx_low_n++;
            busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_rx(input int target, input int limit);
        int n = 0;
        while (rx_count < target && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic rx_wait(input int n, inout logic abort);
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) abort = 1'b1;
        end
    endtask

    // UART decoder: samples mid-bit, abandons any byte interrupted by reset.
    initial begin : rx_monitor
        logic       prev_tx;
        logic [7:0] data;
        logic       abort;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev_tx === 1'b1 && tx === 1'b0) begin
                abort = 1'b0;
                data  = '0;
                rx_wait(4, abort);
                for (int i = 0; i < 8; i++) begin
                    rx_wait(CPB, abort);
                    data[i] = tx;
                end
                rx_wait(CPB, abort);
                if (!abort) begin
                    check_output("rx_stop_bit", tx, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL rx_unexpected: got %0h, expected no byte", data);
                    end else begin
                        check_output("rx_byte", data, exp_q.pop_front());
                    end
                    rx_count++;
                end
            end
            prev_tx = tx;
        end
    end

    always @(negedge clk) begin
        if (dropped) drop_cycles++;
        if (dropped && !drop_prev) drop_pulses++;
        drop_prev = dropped;
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        int busy_n, tx_low_n, base_rx, base_pulses, base_cycles;

        repeat (3) @(negedge clk);
        check_output("reset_tx", tx, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_dropped", dropped, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] basic message");
        base_rx = rx_count;
        apply_stimulus(TEST_MSG, 1'b1);
        measure_busy(busy_n, tx_low_n);
        check_output("busy_cycles_msg", busy_n, MSG_BUSY);
        release_msg();
        check_output("rx_count_msg", rx_count - base_rx, N_SENT);
        check_output("queue_drained_msg", exp_q.size(), 0);

        $display("[TB] all-zero message");
        base_rx = rx_count;
        apply_stimulus('0, 1'b0);
        measure_busy(busy_n, tx_low_n);
        check_output("busy_cycles_zero", busy_n, ZERO_BUSY);
        check_output("tx_low_zero", tx_low_n, 0);
        release_msg();
        check_output("rx_count_zero", rx_count - base_rx, 0);

        $display("[TB] retrigger while busy");
        base_rx     = rx_count;
        base_pulses = drop_pulses;
        base_cycles = drop_cycles;
        apply_stimulus(TEST_MSG, 1'b1);
        wait_rx(base_rx + 2, 3000);
        repeat (20) @(negedge clk);
        delivery_msg = 1'b0;
        repeat (5) @(negedge clk);
        delivery_msg = 1'b1;
        measure_busy(busy_n, tx_low_n);
        check_output("dropped_pulses", drop_pulses - base_pulses, 1);
        check_output("dropped_width", drop_cycles - base_cycles, 1);
        check_output("rx_count_retrig", rx_count - base_rx, N_SENT);
        check_output("queue_drained_retrig", exp_q.size(), 0);
        release_msg();

        $display("[TB] level held high");
        base_rx     = rx_count;
        base_pulses = drop_pulses;
        apply_stimulus(TEST_MSG, 1'b1);
        repeat (5000) @(negedge clk);
        check_output("rx_count_held", rx_count - base_rx, N_SENT);
        check_output("queue_drained_held", exp_q.size(), 0);
        check_output("busy_after_held", busy, 0);
        check_output("dropped_held", drop_pulses - base_pulses, 0);
        release_msg();

        $display("[TB] reset mid-frame");
        base_rx = rx_count;
        apply_stimulus(TEST_MSG, 1'b1);
        wait_rx(base_rx + 1, 3000);
        busy_n = 0;
        while (tx !== 1'b0 && busy_n < 200) begin
            @(negedge clk);
            busy_n++;
        end
        repeat (54) @(negedge clk);
        check_output("tx_bit4_before_reset", tx, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_tx", tx, 1);
        check_output("async_reset_busy", busy, 0);
        check_output("async_reset_dropped", dropped, 0);
        exp_q.delete();
        delivery_msg = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_output("rx_count_reset", rx_count - base_rx, 1);

        base_rx = rx_count;
        apply_stimulus(TEST_MSG, 1'b1);
        measure_busy(busy_n, tx_low_n);
        check_output("busy_cycles_after_reset", busy_n, MSG_BUSY);
        release_msg();
        check_output("rx_count_after_reset", rx_count - base_rx, N_SENT);
        check_output("queue_drained_after_reset", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
